knight_rider_monitor: RTL and testbench
=======================================

Name: knight_rider_monitor

Overview:
- Observes the 8-bit Knight Rider LED bus and encodes it back to a 3-bit position.
- Tracks scan direction, checks that each update is a legal single-step move, and counts completed round-trip sweeps.
- Sits beside the LED scanner as an on-chip checker, or on the receive side of a board link carrying the LED bus.
- All outputs are registered.

Parameters:
- CNT_W, 8: width of sweep_count.
- LOCK_STEPS, 4: consecutive legal steps required before locked asserts; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sample_en  input  1  leds is valid and is sampled this cycle.
- leds  input  8  LED bus; bit i lit means position i.
- clr_err  input  1  synchronous clear of the sticky error flags.
- pos  output  3  last valid encoded position.
- pos_valid  output  1  pos holds a one-hot-derived value.
- dir  output  1  0 = ascending (toward 7), 1 = descending (toward 0).
- locked  output  1  tracking with at least LOCK_STEPS consecutive legal steps.
- sweep_count  output  CNT_W  completed round trips; wraps modulo 2^CNT_W.
- err_onehot  output  1  sticky: a sample was zero or had more than one bit lit.
- err_step  output  1  sticky: a sample was an illegal move.

Behaviour:
- Reset (reset=0, async): pos=0, pos_valid=0, dir=0, locked=0, sweep_count=0, err_onehot=0, err_step=0, lock counter=0, state=S_IDLE.
- Reset released mid-sweep: the block restarts acquisition from S_IDLE.
- Latency: outputs reflect a sample on the clock edge after sample_en=1. When sample_en=0, all state holds.
- States and transitions, evaluated only when sample_en=1. Let p = previous pos, n = new pos.
  - S_IDLE: one-hot sample -> latch pos, pos_valid=1, go to S_FIRST.
  - S_FIRST: n=p+1 -> S_UP, dir=0. n=p-1 -> S_DOWN, dir=1. n=p -> hold. Any other n -> err_step, stay in S_FIRST with pos=n.
  - S_UP: n=p+1 (p<7) is legal. p=7 and n=6 is legal: go to S_DOWN, dir=1.
  - S_DOWN: n=p-1 (p>0) is legal. p=0 and n=1 is legal: go to S_UP, dir=0, sweep_count+1.
  - Hold (n=p) in any tracking state: legal no-op. Lock counter is neither incremented nor cleared.
- Illegal step in S_UP/S_DOWN (non-adjacent jump, or a reversal away from an end): err_step=1, pos=n, lock counter=0, go to S_FIRST (resync).
- Non-one-hot sample in any state: err_onehot=1, pos_valid=0, pos holds, lock counter=0, go to S_IDLE.
- Lock counter: +1 per legal non-hold step, saturating at LOCK_STEPS. locked = (state is S_UP or S_DOWN) and counter == LOCK_STEPS.
- Error flags: set by their events, cleared only by clr_err. If clr_err and a new error occur in the same cycle, the set wins.
- sweep_count: wraps from 2^CNT_W-1 to 0 without any flag.

Optional Feature:
- Macro: KR_MON_ERRCNT_EN.
- Defined: adds output port err_count (8 bits). It increments on every err_onehot or err_step event (by 1 if both fire in one cycle), saturates at 255, is reset to 0, and is cleared by clr_err. Same-cycle clr_err plus error leaves it at 1.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package kr_pkg holds:
  - N_LEDS=8, POS_W=3, POS_MAX=7;
  - the state typedef (S_IDLE, S_FIRST, S_UP, S_DOWN);
  - DIR_UP=0, DIR_DOWN=1.
- Sub-module encoder8to3 is the combinational inverse of the scanner's 3-to-8 decoder. Inputs: in[7:0]. Outputs: out[2:0] and onehot (exactly one bit set).
- The FSM, counters and flags stay in the top module.

Test Plan:
- Reset, then 16 samples of leds 0x01,0x02,...,0x80,0x40,...,0x01,0x02: locked=1 from the 5th sample onward, dir toggles at 0x80 and 0x01, sweep_count=1, no errors.
- Locked ascending at pos 3, then a sample of 0x40: err_step=1, pos=6, locked=0, state S_FIRST. Next 0x80 gives dir=0 and tracking resumes.
- Sample of 0x00, then 0x18: err_onehot=1 and pos_valid=0 after each, pos holds its last valid value. Next 0x08 gives pos_valid=1, pos=3.
- clr_err and an illegal sample in the same cycle: err_step stays 1. clr_err alone on the next cycle: err_step=0.
- Hold: sample 0x04 three times while tracking: no error, lock count unchanged. Assert reset mid-sweep: all outputs return to reset values asynchronously.
- With CNT_W=2, run 4 round trips: sweep_count goes 1,2,3,0. With KR_MON_ERRCNT_EN, 300 illegal samples give err_count=255.

Source files
------------

// File: rtl/kr_pkg.sv
// Shared types and constants for the Knight Rider LED bus monitor.
// Optional error counter: define KR_MON_ERRCNT_EN.
package kr_pkg;
   localparam int N_LEDS = 8;
   localparam int POS_W  = 3;
   localparam logic [POS_W-1:0] POS_MAX = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FIRST,
      S_UP,
      S_DOWN
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/knight_rider_monitor_enc.sv
// encoder8to3: LED bus back to a 3-bit position.
// onehot is high only when exactly one LED is lit.
import kr_pkg::*;

module encoder8to3 (
   input  logic [N_LEDS-1:0] in,
   output logic [POS_W-1:0]  out,
   output logic              onehot
);
   always_comb begin
      out = '0;
      for (int i = 0; i < N_LEDS; i++) begin
         if (in[i]) out = i[POS_W-1:0];
      end
      onehot = (in != '0) && ((in & (in - 1'b1)) == '0);
   end
endmodule

// File: rtl/knight_rider_monitor.sv
// Knight Rider LED bus checker: position, direction, lock, sweeps.
// Define KR_MON_ERRCNT_EN to add the saturating err_count output.
import kr_pkg::*;

module knight_rider_monitor #(
   parameter int CNT_W      = 8,
   parameter int LOCK_STEPS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_en,
   input  logic [7:0]        leds,
   input  logic              clr_err,
   output logic [2:0]        pos,
   output logic              pos_valid,
   output logic              dir,
   output logic              locked,
   output logic [CNT_W-1:0]  sweep_count,
   output logic              err_onehot,
`ifdef KR_MON_ERRCNT_EN
   output logic              err_step,
   output logic [7:0]        err_count
`else
   output logic              err_step
`endif
);
   localparam int LK_W = 4;
   localparam logic [LK_W-1:0] LOCK_MAX = LK_W'(LOCK_STEPS);

   state_t             state_q, state_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               pv_q, pv_d;
   logic               dir_q, dir_d;
   logic [LK_W-1:0]    cnt_q, cnt_d;
   logic               locked_q, locked_d;
   logic [CNT_W-1:0]   sweep_q, sweep_d;
   logic               eoh_q, eoh_d;
   logic               est_q, est_d;
   logic               ev_oh, ev_st;

   logic [POS_W-1:0]   n;
   logic               n_oh;
   logic               hold, step_up, step_dn;
   logic [LK_W-1:0]    cnt_inc;

   encoder8to3 u_enc (
      .in     (leds),
      .out    (n),
      .onehot (n_oh)
   );

   // Guards keep p+1 / p-1 from wrapping around the 3-bit range.
   assign hold    = (n == pos_q);
   assign step_up = (pos_q != POS_MAX) && (n == pos_q + 3'd1);
   assign step_dn = (pos_q != '0) && (n == pos_q - 3'd1);
   assign cnt_inc = (cnt_q == LOCK_MAX) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         pos_q    <= '0;
         pv_q     <= 1'b0;
         dir_q    <= DIR_UP;
         cnt_q    <= '0;
         locked_q <= 1'b0;
         sweep_q  <= '0;
         eoh_q    <= 1'b0;
         est_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         pv_q     <= pv_d;
         dir_q    <= dir_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
         sweep_q  <= sweep_d;
         eoh_q    <= eoh_d;
         est_q    <= est_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      pv_d    = pv_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      sweep_d = sweep_q;
      ev_oh   = 1'b0;
      ev_st   = 1'b0;
      if (sample_en) begin
         if (!n_oh) begin
            ev_oh   = 1'b1;
            pv_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  pos_d   = n;
                  pv_d    = 1'b1;
                  state_d = S_FIRST;
               end
               S_FIRST: begin
                  unique case (1'b1)
                     hold: ;
                     step_up: begin
                        pos_d   = n;
                        dir_d   = DIR_UP;
                        cnt_d   = cnt_inc;
                        state_d = S_UP;
                     end
                     step_dn: begin
                        pos_d   = n;
                        dir_d   = DIR_DOWN;
                        cnt_d   = cnt_inc;
                        state_d = S_DOWN;
                     end
                     default: begin
                        ev_st = 1'b1;
                        pos_d = n;
                        cnt_d = '0;
                     end
                  endcase
               end
               S_UP: begin
                  unique case (1'b1)
                     hold: ;
                     step_up: begin
                        pos_d = n;
                        cnt_d = cnt_inc;
                     end
                     (step_dn && pos_q == POS_MAX): begin
                        pos_d   = n;
                        dir_d   = DIR_DOWN;
                        cnt_d   = cnt_inc;
                        state_d = S_DOWN;
                     end
                     default: begin
                        ev_st   = 1'b1;
                        pos_d   = n;
                        cnt_d   = '0;
                        state_d = S_FIRST;
                     end
                  endcase
               end
               S_DOWN: begin
                  unique case (1'b1)
                     hold: ;
                     step_dn: begin
                        pos_d = n;
                        cnt_d = cnt_inc;
                     end
                     (step_up && pos_q == '0): begin
                        pos_d   = n;
                        dir_d   = DIR_UP;
                        cnt_d   = cnt_inc;
                        sweep_d = sweep_q + CNT_W'(1);
                        state_d = S_UP;
                     end
                     default: begin
                        ev_st   = 1'b1;
                        pos_d   = n;
                        cnt_d   = '0;
                        state_d = S_FIRST;
                     end
                  endcase
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
      locked_d = ((state_d == S_UP) || (state_d == S_DOWN))
                 && (cnt_d == LOCK_MAX);
      // A new error outranks a same-cycle clear.
      eoh_d = (eoh_q & ~clr_err) | ev_oh;
      est_d = (est_q & ~clr_err) | ev_st;
   end

`ifdef KR_MON_ERRCNT_EN
   logic [7:0] ec_q, ec_d;
   logic [8:0] ec_sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ec_q <= '0;
      else        ec_q <= ec_d;
   end

   always_comb begin
      ec_sum = {1'b0, (clr_err ? 8'd0 : ec_q)}
               + {8'd0, ev_oh} + {8'd0, ev_st};
      ec_d   = ec_sum[8] ? 8'hFF : ec_sum[7:0];
   end
`endif

   always_comb begin
      pos         = pos_q;
      pos_valid   = pv_q;
      dir         = dir_q;
      locked      = locked_q;
      sweep_count = sweep_q;
      err_onehot  = eoh_q;
      err_step    = est_q;
`ifdef KR_MON_ERRCNT_EN
      err_count   = ec_q;
`endif
   end
endmodule

// File: tb/tb_knight_rider_monitor.sv
// Scoreboard bench for knight_rider_monitor (default and CNT_W=2).
// Covers the err_count path when KR_MON_ERRCNT_EN is defined.
module tb_knight_rider_monitor;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sample_en = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] leds = 8'h00;

   logic [2:0] pos, pos2;
   logic       pv, pv2, dir, dir2, lk, lk2;
   logic [7:0] sw;
   logic [1:0] sw2;
   logic       eoh, eoh2, est, est2;
`ifdef KR_MON_ERRCNT_EN
   logic [7:0] ec, ec2;
`endif

   typedef struct {
      logic [2:0] pos;
      logic       pv;
      logic       dir;
      logic       lk;
      logic [7:0] sw;
      logic       eoh;
      logic       est;
      logic       chk_ec;
      logic [7:0] ec;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   knight_rider_monitor u_dut (
      .clk         (clk),
      .reset       (reset),
      .sample_en   (sample_en),
      .leds        (leds),
      .clr_err     (clr_err),
      .pos         (pos),
      .pos_valid   (pv),
      .dir         (dir),
      .locked      (lk),
      .sweep_count (sw),
      .err_onehot  (eoh),
`ifdef KR_MON_ERRCNT_EN
      .err_step    (est),
      .err_count   (ec)
`else
      .err_step    (est)
`endif
   );

   knight_rider_monitor #(.CNT_W(2)) u_dut2 (
      .clk         (clk),
      .reset       (reset),
      .sample_en   (sample_en),
      .leds        (leds),
      .clr_err     (clr_err),
      .pos         (pos2),
      .pos_valid   (pv2),
      .dir         (dir2),
      .locked      (lk2),
      .sweep_count (sw2),
      .err_onehot  (eoh2),
`ifdef KR_MON_ERRCNT_EN
      .err_step    (est2),
      .err_count   (ec2)
`else
      .err_step    (est2)
`endif
   );

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   // Monitor: one expected record per sampled clock edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pos", int'(pos), int'(e.pos));
            chk("pos_valid", int'(pv), int'(e.pv));
            chk("dir", int'(dir), int'(e.dir));
            chk("locked", int'(lk), int'(e.lk));
            chk("sweep", int'(sw), int'(e.sw));
            chk("sweep_w2", int'(sw2), int'(e.sw[1:0]));
            chk("err_onehot", int'(eoh), int'(e.eoh));
            chk("err_step", int'(est), int'(e.est));
`ifdef KR_MON_ERRCNT_EN
            if (e.chk_ec) chk("err_count", int'(ec), int'(e.ec));
`endif
         end
      end
   end

   task automatic push(input logic en, input logic [7:0] l,
                       input logic c, input exp_t e);
      @(negedge clk);
      sample_en = en;
      leds      = l;
      clr_err   = c;
      @(posedge clk);
      q.push_back(e);
   endtask

   task automatic drv(input logic en, input logic [7:0] l,
                      input logic c, input logic [2:0] p,
                      input logic v, input logic d, input logic k,
                      input logic [7:0] s, input logic o,
                      input logic t);
      exp_t e;
      e.pos = p; e.pv = v; e.dir = d; e.lk = k;
      e.sw = s; e.eoh = o; e.est = t;
      e.chk_ec = 1'b0; e.ec = 8'd0;
      push(en, l, c, e);
   endtask

   task automatic s(input logic [7:0] l, input logic c,
                    input logic [2:0] p, input logic v,
                    input logic d, input logic k,
                    input logic [7:0] sv, input logic o,
                    input logic t);
      drv(1'b1, l, c, p, v, d, k, sv, o, t);
   endtask

   task automatic quiet();
      @(negedge clk);
      sample_en = 1'b0;
      clr_err   = 1'b0;
      leds      = 8'h00;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b1;
      drv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);

      // full sweep and back
      s(8'h01, 0, 0, 1, 0, 0, 0, 0, 0);
      s(8'h02, 0, 1, 1, 0, 0, 0, 0, 0);
      s(8'h04, 0, 2, 1, 0, 0, 0, 0, 0);
      s(8'h08, 0, 3, 1, 0, 0, 0, 0, 0);
      s(8'h10, 0, 4, 1, 0, 1, 0, 0, 0);
      s(8'h20, 0, 5, 1, 0, 1, 0, 0, 0);
      s(8'h40, 0, 6, 1, 0, 1, 0, 0, 0);
      s(8'h80, 0, 7, 1, 0, 1, 0, 0, 0);
      s(8'h40, 0, 6, 1, 1, 1, 0, 0, 0);
      s(8'h20, 0, 5, 1, 1, 1, 0, 0, 0);
      s(8'h10, 0, 4, 1, 1, 1, 0, 0, 0);
      s(8'h08, 0, 3, 1, 1, 1, 0, 0, 0);
      s(8'h04, 0, 2, 1, 1, 1, 0, 0, 0);
      s(8'h02, 0, 1, 1, 1, 1, 0, 0, 0);
      s(8'h01, 0, 0, 1, 1, 1, 0, 0, 0);
      s(8'h02, 0, 1, 1, 0, 1, 1, 0, 0);

      // illegal jump while locked, then resync
      s(8'h04, 0, 2, 1, 0, 1, 1, 0, 0);
      s(8'h08, 0, 3, 1, 0, 1, 1, 0, 0);
      s(8'h40, 0, 6, 1, 0, 0, 1, 0, 1);
      s(8'h80, 0, 7, 1, 0, 0, 1, 0, 1);
      s(8'h40, 0, 6, 1, 1, 0, 1, 0, 1);
      drv(0, 8'h00, 1, 6, 1, 1, 0, 1, 0, 0);

      // non-one-hot samples
      s(8'h00, 0, 6, 0, 1, 0, 1, 1, 0);
      s(8'h18, 0, 6, 0, 1, 0, 1, 1, 0);
      s(8'h08, 0, 3, 1, 1, 0, 1, 1, 0);

      // clear racing a new step error
      s(8'h80, 1, 7, 1, 1, 0, 1, 0, 1);
      drv(0, 8'h00, 1, 7, 1, 1, 0, 1, 0, 0);

      // holds do not touch the lock counter
      s(8'h08, 0, 3, 1, 1, 0, 1, 0, 1);
      s(8'h04, 1, 2, 1, 1, 0, 1, 0, 0);
      s(8'h04, 0, 2, 1, 1, 0, 1, 0, 0);
      s(8'h04, 0, 2, 1, 1, 0, 1, 0, 0);
      s(8'h04, 0, 2, 1, 1, 0, 1, 0, 0);
      s(8'h02, 0, 1, 1, 1, 0, 1, 0, 0);
      s(8'h01, 0, 0, 1, 1, 0, 1, 0, 0);
      s(8'h02, 0, 1, 1, 0, 1, 2, 0, 0);
      s(8'h01, 0, 0, 1, 0, 0, 2, 0, 1);
      s(8'h02, 0, 1, 1, 0, 0, 2, 0, 1);
      s(8'h04, 0, 2, 1, 0, 0, 2, 0, 1);

      // asynchronous reset mid-sweep
      quiet();
      #2 reset = 1'b0;
      #1;
      chk("rst_pos", int'(pos), 0);
      chk("rst_pv", int'(pv), 0);
      chk("rst_sweep", int'(sw), 0);
      chk("rst_sweep_w2", int'(sw2), 0);
      chk("rst_err_step", int'(est), 0);
      @(negedge clk);
      reset = 1'b1;
      drv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);

      // four round trips; narrow counter wraps 1,2,3,0
      s(8'h01, 0, 0, 1, 0, 0, 0, 0, 0);
      for (int t = 0; t < 4; t++) begin
         for (int k = 1; k <= 7; k++)
            s(8'(1 << k), 0, 3'(k), 1, 0,
              !(t == 0 && k < 4), 8'(t), 0, 0);
         for (int k = 6; k >= 0; k--)
            s(8'(1 << k), 0, 3'(k), 1, 1, 1, 8'(t), 0, 0);
      end
      s(8'h02, 0, 1, 1, 0, 1, 4, 0, 0);

`ifdef KR_MON_ERRCNT_EN
      begin
         exp_t e;
         e.pos = 3'd1; e.pv = 1'b1; e.dir = 1'b0; e.lk = 1'b1;
         e.sw = 8'd4; e.eoh = 1'b0; e.est = 1'b0;
         e.chk_ec = 1'b1; e.ec = 8'd0;
         push(1'b0, 8'h00, 1'b1, e);
         e.pv = 1'b0; e.lk = 1'b0; e.eoh = 1'b1;
         for (int i = 1; i <= 300; i++) begin
            e.ec = (i > 255) ? 8'd255 : 8'(i);
            push(1'b1, 8'h00, 1'b0, e);
         end
         e.ec = 8'd1;
         push(1'b1, 8'h00, 1'b1, e);
      end
`endif

      quiet();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
